ising_host_sequencer: RTL and testbench



---
 rtl/ising_host_sequencer.sv | 218 +++++++++++++++++++++
 tb/tb_ising_host_sequencer.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ising_host_sequencer.sv
// Host-side sequencer for the Ising calculation block: streams weight rows onto WBL/WWL,
// starts annealing, collects the result over a synchronized done/done_ack handshake.
module ising_host_sequencer #(
  parameter int ARRAY_SIZE   = 50,
  parameter int WORD_WIDTH   = 4,
  parameter int ENERGY_WIDTH = 16,
  parameter int DATA_WIDTH   = 32
) (
  input  logic                             axi_clk,
  input  logic                             resetb,
  input  logic                             start,
  input  logic                             reuse_weights,
  input  logic [7:0]                       wl_pulse_cycles,
  input  logic [DATA_WIDTH-1:0]            timeout_cycles,
  input  logic                             row_valid,
  output logic                             row_ready,
  input  logic [ARRAY_SIZE*WORD_WIDTH-1:0] row_data,
  output logic [ARRAY_SIZE*WORD_WIDTH-1:0] WBL,
  output logic [ARRAY_SIZE-1:0]            WWL,
  output logic                             prog_done,
  input  logic                             done,
  output logic                             done_ack,
  input  logic [ENERGY_WIDTH-1:0]          best_hamiltonian,
  input  logic [ARRAY_SIZE-5:0]            best_spins,
  output logic                             result_valid,
  input  logic                             result_ready,
  output logic [ENERGY_WIDTH-1:0]          result_hamiltonian,
  output logic [ARRAY_SIZE-5:0]            result_spins,
  output logic                             result_timeout,
  output logic                             busy
);

  localparam int ROW_W = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1;
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ARRAY_SIZE - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ROW_WAIT = 3'd1,
    SETUP    = 3'd2,
    PULSE    = 3'd3,
    HOLD     = 3'd4,
    RUN      = 3'd5,
    ACK      = 3'd6,
    RESULT   = 3'd7
  } state_t;

  state_t                  state_r;
  state_t                  next_state_s;
  logic                    done_meta_r;
  logic                    done_s;
  logic [ROW_W-1:0]        row_r;
  logic [7:0]              pulse_cnt_r;
  logic [DATA_WIDTH-1:0]   run_cnt_r;
  logic                    loaded_r;
  logic                    timeout_hit_s;
  logic                    reuse_ok_s;
  logic [ARRAY_SIZE-1:0]   row_onehot_s;
  logic                    row_ready_nxt_s;
  logic                    prog_done_nxt_s;
  logic                    done_ack_nxt_s;
  logic                    result_valid_nxt_s;
  logic                    busy_nxt_s;
  logic [ARRAY_SIZE-1:0]   wwl_nxt_s;

  assign timeout_hit_s = (timeout_cycles != {DATA_WIDTH{1'b0}}) &&
                         (run_cnt_r == timeout_cycles - DATA_WIDTH'(1));
  assign reuse_ok_s    = reuse_weights && loaded_r;

  // Two-flop synchronizer for the DCO-domain done.
  always_ff @(posedge axi_clk or negedge resetb) begin
    if (!resetb) begin
      done_meta_r <= 1'b0;
      done_s      <= 1'b0;
    end else begin
      done_meta_r <= done;
      done_s      <= done_meta_r;
    end
  end

  // State register.
  always_ff @(posedge axi_clk or negedge resetb) begin
    if (!resetb) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; done_s takes priority over the timeout in RUN.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          if (reuse_ok_s) next_state_s = RUN;
          else            next_state_s = ROW_WAIT;
        end else begin
          next_state_s = IDLE;
        end
      end
      ROW_WAIT: begin
        if (row_valid) next_state_s = SETUP;
        else           next_state_s = ROW_WAIT;
      end
      SETUP: next_state_s = PULSE;
      PULSE: begin
        if (pulse_cnt_r == 8'd0) next_state_s = HOLD;
        else                     next_state_s = PULSE;
      end
      HOLD: begin
        if (row_r == LAST_ROW) next_state_s = RUN;
        else                   next_state_s = ROW_WAIT;
      end
      RUN: begin
        if (done_s)             next_state_s = ACK;
        else if (timeout_hit_s) next_state_s = RESULT;
        else                    next_state_s = RUN;
      end
      ACK: begin
        if (!done_s) next_state_s = RESULT;
        else         next_state_s = ACK;
      end
      RESULT: begin
        if (result_ready) next_state_s = IDLE;
        else              next_state_s = RESULT;
      end
      default: next_state_s = IDLE;
    endcase
  end

  // Output decode from the next state so every output leaves a flop aligned with its state.
  always_comb begin
    row_onehot_s       = {ARRAY_SIZE{1'b0}};
    row_onehot_s[row_r] = 1'b1;
    row_ready_nxt_s    = (next_state_s == ROW_WAIT);
    prog_done_nxt_s    = (next_state_s == RUN) || (next_state_s == ACK);
    done_ack_nxt_s     = (next_state_s == ACK);
    result_valid_nxt_s = (next_state_s == RESULT);
    busy_nxt_s         = (next_state_s != IDLE);
    if (next_state_s == PULSE) begin
      wwl_nxt_s = row_onehot_s;
    end else begin
      wwl_nxt_s = {ARRAY_SIZE{1'b0}};
    end
  end

  // Registered control outputs.
  always_ff @(posedge axi_clk or negedge resetb) begin
    if (!resetb) begin
      row_ready    <= 1'b0;
      prog_done    <= 1'b0;
      done_ack     <= 1'b0;
      result_valid <= 1'b0;
      busy         <= 1'b0;
      WWL          <= {ARRAY_SIZE{1'b0}};
    end else begin
      row_ready    <= row_ready_nxt_s;
      prog_done    <= prog_done_nxt_s;
      done_ack     <= done_ack_nxt_s;
      result_valid <= result_valid_nxt_s;
      busy         <= busy_nxt_s;
      WWL          <= wwl_nxt_s;
    end
  end

  // Datapath: row/pulse/run counters, loaded flag, bit lines and result capture.
  always_ff @(posedge axi_clk or negedge resetb) begin
    if (!resetb) begin
      row_r              <= {ROW_W{1'b0}};
      pulse_cnt_r        <= 8'd0;
      run_cnt_r          <= {DATA_WIDTH{1'b0}};
      loaded_r           <= 1'b0;
      WBL                <= {(ARRAY_SIZE*WORD_WIDTH){1'b0}};
      result_hamiltonian <= {ENERGY_WIDTH{1'b0}};
      result_spins       <= {(ARRAY_SIZE-4){1'b0}};
      result_timeout     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            row_r          <= {ROW_W{1'b0}};
            run_cnt_r      <= {DATA_WIDTH{1'b0}};
            result_timeout <= 1'b0;
            if (!reuse_ok_s) loaded_r <= 1'b0;
          end
        end
        ROW_WAIT: begin
          if (row_valid) WBL <= row_data;
        end
        SETUP: begin
          // Pulse width sampled here; zero is treated as a single cycle.
          if (wl_pulse_cycles == 8'd0) pulse_cnt_r <= 8'd0;
          else                         pulse_cnt_r <= wl_pulse_cycles - 8'd1;
        end
        PULSE: begin
          if (pulse_cnt_r != 8'd0) pulse_cnt_r <= pulse_cnt_r - 8'd1;
        end
        HOLD: begin
          if (row_r == LAST_ROW) loaded_r <= 1'b1;
          else                   row_r    <= row_r + ROW_W'(1);
        end
        RUN: begin
          run_cnt_r <= run_cnt_r + DATA_WIDTH'(1);
          if (done_s) begin
            result_hamiltonian <= best_hamiltonian;
            result_spins       <= best_spins;
          end else if (timeout_hit_s) begin
            result_timeout     <= 1'b1;
            result_hamiltonian <= {ENERGY_WIDTH{1'b0}};
            result_spins       <= {(ARRAY_SIZE-4){1'b0}};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ising_host_sequencer.sv
// Self-checking bench for ising_host_sequencer: row loading timing, done handshake,
// timeout, weight reuse and asynchronous reset, against a cycle-level reference of the protocol.
module tb_ising_host_sequencer;

  localparam int N  = 50;
  localparam int WW = 4;
  localparam int EW = 16;
  localparam int DW = 32;
  localparam int SW = N - 4;
  localparam int RB = N * WW;

  logic          axi_clk = 1'b0;
  logic          resetb;
  logic          start;
  logic          reuse_weights;
  logic [7:0]    wl_pulse_cycles;
  logic [DW-1:0] timeout_cycles;
  logic          row_valid;
  logic          row_ready;
  logic [RB-1:0] row_data;
  logic [RB-1:0] WBL;
  logic [N-1:0]  WWL;
  logic          prog_done;
  logic          done;
  logic          done_ack;
  logic [EW-1:0] best_hamiltonian;
  logic [SW-1:0] best_spins;
  logic          result_valid;
  logic          result_ready;
  logic [EW-1:0] result_hamiltonian;
  logic [SW-1:0] result_spins;
  logic          result_timeout;
  logic          busy;

  int errors = 0;
  int checks = 0;

  ising_host_sequencer #(
    .ARRAY_SIZE(N), .WORD_WIDTH(WW), .ENERGY_WIDTH(EW), .DATA_WIDTH(DW)
  ) dut (
    .axi_clk(axi_clk), .resetb(resetb), .start(start), .reuse_weights(reuse_weights),
    .wl_pulse_cycles(wl_pulse_cycles), .timeout_cycles(timeout_cycles),
    .row_valid(row_valid), .row_ready(row_ready), .row_data(row_data),
    .WBL(WBL), .WWL(WWL), .prog_done(prog_done), .done(done), .done_ack(done_ack),
    .best_hamiltonian(best_hamiltonian), .best_spins(best_spins),
    .result_valid(result_valid), .result_ready(result_ready),
    .result_hamiltonian(result_hamiltonian), .result_spins(result_spins),
    .result_timeout(result_timeout), .busy(busy)
  );

  always #5 axi_clk = ~axi_clk;

  function automatic logic [SW-1:0] rand_spins();
    return SW'({$urandom, $urandom});
  endfunction

  function automatic logic [RB-1:0] rand_row();
    logic [RB-1:0] d;
    for (int w = 0; w < N; w++) d[w*WW +: WW] = WW'($urandom);
    return d;
  endfunction

  task automatic do_start(input bit reuse);
    start = 1'b1;
    reuse_weights = reuse;
    @(negedge axi_clk);
    start = 1'b0;
    reuse_weights = 1'b0;
  endtask

  // Host closes the result handshake; a start in the same cycle must be ignored.
  task automatic finish_result(input logic [EW-1:0] exp_ham, input logic [SW-1:0] exp_spins);
    repeat ($urandom_range(0, 3)) @(negedge axi_clk);
    checks++;
    if (result_valid !== 1'b1 || result_hamiltonian !== exp_ham || result_spins !== exp_spins) begin
      errors++;
      $display("FAIL result_stable: valid=%b ham=%h spins=%h expected valid=1 ham=%h spins=%h",
               result_valid, result_hamiltonian, result_spins, exp_ham, exp_spins);
    end
    result_ready = 1'b1;
    start = 1'b1;
    @(negedge axi_clk);
    result_ready = 1'b0;
    start = 1'b0;
    checks++;
    if (result_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL result_release: valid=%b busy=%b expected 0 0", result_valid, busy);
    end
    @(negedge axi_clk);
    checks++;
    if (busy !== 1'b0 || row_ready !== 1'b0) begin
      errors++;
      $display("FAIL start_with_handshake: busy=%b row_ready=%b expected 0 0", busy, row_ready);
    end
  endtask

  // Streams all rows. Called at the negedge where ROW_WAIT is visible; returns at the
  // negedge where prog_done should first be visible (or after an injected reset).
  task automatic load_rows(input int p, input int max_gap, input bit rep_data,
                           input bit inject_start, input int abort_row);
    int            peff;
    logic [RB-1:0] d;
    logic [N-1:0]  oh;
    peff = (p == 0) ? 1 : p;
    wl_pulse_cycles = 8'(p);
    for (int r = 0; r < N; r++) begin
      if (max_gap > 0) repeat ($urandom_range(0, max_gap)) @(negedge axi_clk);
      checks++;
      if (row_ready !== 1'b1 || prog_done !== 1'b0) begin
        errors++;
        $display("FAIL row_ready_r%0d: row_ready=%b prog_done=%b expected 1 0", r, row_ready, prog_done);
      end
      if (rep_data) for (int w = 0; w < N; w++) d[w*WW +: WW] = WW'(r);
      else d = rand_row();
      oh = '0;
      oh[r] = 1'b1;
      row_valid = 1'b1;
      row_data = d;
      @(negedge axi_clk);
      row_valid = 1'b0;
      row_data = rand_row();
      checks++;
      if (WWL !== '0 || WBL !== d || row_ready !== 1'b0) begin
        errors++;
        $display("FAIL setup_r%0d: WWL=%h WBL=%h row_ready=%b expected WWL=0 WBL=%h row_ready=0",
                 r, WWL, WBL, row_ready, d);
      end
      if (inject_start && r == 10) start = 1'b1;
      for (int k = 0; k < peff; k++) begin
        @(negedge axi_clk);
        start = 1'b0;
        checks++;
        if (WWL !== oh || WBL !== d) begin
          errors++;
          $display("FAIL pulse_r%0d_c%0d: WWL=%h WBL=%h expected WWL=%h WBL=%h", r, k, WWL, WBL, oh, d);
        end
        if (r == abort_row && k == 0) begin
          resetb = 1'b0;
          #1;
          checks++;
          if (WWL !== '0 || busy !== 1'b0 || prog_done !== 1'b0 || row_ready !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: WWL=%h busy=%b prog_done=%b row_ready=%b expected all 0",
                     WWL, busy, prog_done, row_ready);
          end
          @(negedge axi_clk);
          resetb = 1'b1;
          @(negedge axi_clk);
          return;
        end
      end
      @(negedge axi_clk);
      checks++;
      if (WWL !== '0 || WBL !== d) begin
        errors++;
        $display("FAIL hold_r%0d: WWL=%h WBL=%h expected WWL=0 WBL=%h", r, WWL, WBL, d);
      end
      @(negedge axi_clk);
      if (r == N - 1) begin
        checks++;
        if (prog_done !== 1'b1 || row_ready !== 1'b0 || WWL !== '0 || WBL !== d) begin
          errors++;
          $display("FAIL prog_done_rise: prog_done=%b row_ready=%b WWL=%h expected 1 0 0",
                   prog_done, row_ready, WWL);
        end
      end
    end
  endtask

  // Called at the negedge where prog_done first shows; done raised `delay` cycles later.
  task automatic done_handshake(input int delay, input logic [EW-1:0] ham, input logic [SW-1:0] spins);
    repeat (delay) @(negedge axi_clk);
    checks++;
    if (prog_done !== 1'b1 || result_valid !== 1'b0 || done_ack !== 1'b0) begin
      errors++;
      $display("FAIL run_state: prog_done=%b result_valid=%b done_ack=%b expected 1 0 0",
               prog_done, result_valid, done_ack);
    end
    done = 1'b1;
    best_hamiltonian = ham;
    best_spins = spins;
    repeat (2) @(negedge axi_clk);
    checks++;
    if (done_ack !== 1'b0) begin
      errors++;
      $display("FAIL ack_early: done_ack=%b expected 0 two cycles after done", done_ack);
    end
    @(negedge axi_clk);
    checks++;
    if (done_ack !== 1'b1 || prog_done !== 1'b1) begin
      errors++;
      $display("FAIL ack_rise: done_ack=%b prog_done=%b expected 1 1", done_ack, prog_done);
    end
    repeat ($urandom_range(0, 5)) @(negedge axi_clk);
    done = 1'b0;
    best_hamiltonian = EW'($urandom);
    best_spins = rand_spins();
    repeat (2) @(negedge axi_clk);
    checks++;
    if (done_ack !== 1'b1 || result_valid !== 1'b0) begin
      errors++;
      $display("FAIL ack_hold: done_ack=%b result_valid=%b expected 1 0", done_ack, result_valid);
    end
    @(negedge axi_clk);
    checks++;
    if (done_ack !== 1'b0 || result_valid !== 1'b1 || prog_done !== 1'b0 || result_timeout !== 1'b0 ||
        result_hamiltonian !== ham || result_spins !== spins) begin
      errors++;
      $display("FAIL ack_fall: ack=%b valid=%b prog=%b to=%b ham=%h spins=%h expected 0 1 0 0 %h %h",
               done_ack, result_valid, prog_done, result_timeout, result_hamiltonian, result_spins, ham, spins);
    end
    finish_result(ham, spins);
  endtask

  task automatic test_reset();
    resetb = 1'b0;
    repeat (3) @(negedge axi_clk);
    checks++;
    if ({row_ready, prog_done, done_ack, result_valid, result_timeout, busy} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 000000",
               {row_ready, prog_done, done_ack, result_valid, result_timeout, busy});
    end
    checks++;
    if (WBL !== '0 || WWL !== '0 || result_hamiltonian !== '0 || result_spins !== '0) begin
      errors++;
      $display("FAIL reset_data: WBL=%h WWL=%h ham=%h spins=%h expected all 0",
               WBL, WWL, result_hamiltonian, result_spins);
    end
    resetb = 1'b1;
    @(negedge axi_clk);
  endtask

  task automatic test_done_ignored_idle();
    int bad = 0;
    done = 1'b1;
    repeat (5) begin
      @(negedge axi_clk);
      if (done_ack !== 1'b0 || result_valid !== 1'b0 || busy !== 1'b0) bad++;
    end
    done = 1'b0;
    repeat (4) @(negedge axi_clk);
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL done_in_idle: %0d cycles reacted, expected 0", bad);
    end
  endtask

  // Loaded is clear after reset, so even a reuse request must load all rows.
  task automatic test_full_load();
    timeout_cycles = '0;
    do_start(1'b1);
    checks++;
    if (busy !== 1'b1 || prog_done !== 1'b0) begin
      errors++;
      $display("FAIL first_start: busy=%b prog_done=%b expected 1 0", busy, prog_done);
    end
    load_rows(2, 0, 1'b1, 1'b0, -1);
    done_handshake(10, 16'h00A5, rand_spins());
  endtask

  task automatic test_reuse_timeout(input int t);
    int k = 0;
    int bad = 0;
    timeout_cycles = DW'(t);
    do_start(1'b1);
    checks++;
    if (prog_done !== 1'b1 || row_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL reuse_start: prog_done=%b row_ready=%b busy=%b expected 1 0 1", prog_done, row_ready, busy);
    end
    while (k < t + 20) begin
      @(negedge axi_clk);
      k++;
      if (row_ready !== 1'b0 || WWL !== '0) bad++;
      if (result_valid === 1'b1) break;
    end
    checks++;
    if (k != t || bad != 0) begin
      errors++;
      $display("FAIL timeout_latency: result_valid after %0d cycles (load activity %0d), expected %0d (0)", k, bad, t);
    end
    checks++;
    if (result_timeout !== 1'b1 || result_hamiltonian !== '0 || result_spins !== '0 || prog_done !== 1'b0) begin
      errors++;
      $display("FAIL timeout_result: to=%b ham=%h spins=%h prog=%b expected 1 0 0 0",
               result_timeout, result_hamiltonian, result_spins, prog_done);
    end
    finish_result('0, '0);
    timeout_cycles = '0;
  endtask

  task automatic test_reuse_done();
    timeout_cycles = '0;
    do_start(1'b1);
    checks++;
    if (prog_done !== 1'b1 || row_ready !== 1'b0) begin
      errors++;
      $display("FAIL reuse_done_start: prog_done=%b row_ready=%b expected 1 0", prog_done, row_ready);
    end
    done_handshake($urandom_range(1, 15), EW'($urandom), rand_spins());
  endtask

  task automatic test_reset_mid_pulse();
    timeout_cycles = '0;
    do_start(1'b0);
    load_rows(3, 1, 1'b0, 1'b0, 20);
  endtask

  task automatic test_reload_after_reset();
    timeout_cycles = '0;
    do_start(1'b1);
    checks++;
    if (prog_done !== 1'b0 || row_ready !== 1'b1) begin
      errors++;
      $display("FAIL reload_after_reset: prog_done=%b row_ready=%b expected 0 1", prog_done, row_ready);
    end
    load_rows(0, 3, 1'b0, 1'b1, -1);
    done_handshake($urandom_range(1, 20), EW'($urandom), rand_spins());
  endtask

  initial begin
    resetb = 1'b0;
    start = 1'b0;
    reuse_weights = 1'b0;
    wl_pulse_cycles = 8'd0;
    timeout_cycles = '0;
    row_valid = 1'b0;
    row_data = '0;
    done = 1'b0;
    best_hamiltonian = '0;
    best_spins = '0;
    result_ready = 1'b0;
    test_reset();
    test_done_ignored_idle();
    test_full_load();
    test_reuse_timeout(100);
    test_reuse_done();
    test_reset_mid_pulse();
    test_reload_after_reset();
    test_reuse_timeout($urandom_range(3, 40));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
